// File: rtl/param_digital_lock.sv
// param_digital_lock: sequence-code lock with N key switches and a programmable code.
// Switch levels pass through a synchroniser and edge detector. Each single rising edge
// is one key press and is matched against code_seq step by step. Repeated failures
// raise the alarm for a lockout period.
// Optional feature: define PARAM_LOCK_ENTRY_TIMEOUT_EN to abandon an entry that sits
// idle for ENTRY_TIMEOUT cycles. The abandoned entry counts as a failure.
module param_digital_lock #(
  parameter int NUM_SW         = 8,
  parameter int IDX_W          = 3,
  parameter int CODE_LEN       = 4,
  parameter int UNLOCK_CYCLES  = 10,
  parameter int MAX_FAILS      = 3,
  parameter int LOCKOUT_CYCLES = 50,
  parameter int ENTRY_TIMEOUT  = 20
) (
  input  logic                              clk,
  input  logic                              clear_n,
  input  logic [NUM_SW-1:0]                 sw,
  input  logic [CODE_LEN*IDX_W-1:0]         code_seq,
  input  logic                              relock,
  output logic                              locked,
  output logic                              alarm,
  output logic [$clog2(MAX_FAILS+1)-1:0]    fail_cnt,
  output logic [$clog2(CODE_LEN+1)-1:0]     progress,
  output logic [1:0]                        state_out
);

  localparam int FW  = $clog2(MAX_FAILS + 1);
  localparam int PW  = $clog2(CODE_LEN + 1);
  localparam int TMW = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? $clog2(UNLOCK_CYCLES + 1)
                                                        : $clog2(LOCKOUT_CYCLES + 1);

  // Parameter sanity: code indices must address every switch, and all counts must be non-zero.
  if (2**IDX_W < NUM_SW) begin : g_bad_idx_w
    $error("IDX_W too narrow for NUM_SW");
  end
  if (CODE_LEN < 1 || MAX_FAILS < 1 || UNLOCK_CYCLES < 1 ||
      LOCKOUT_CYCLES < 1 || ENTRY_TIMEOUT < 1) begin : g_bad_count
    $error("lock counts must be at least 1");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, ENTRY = 2'd1, UNLOCKED = 2'd2, ALARM = 2'd3} state_t;

  state_t            state;
  logic [NUM_SW-1:0] sync_p0, sync_p1, hist_p2;
  logic [NUM_SW-1:0] rise;
  logic              any_rise, single_rise, step_match;
  logic [IDX_W-1:0]  rise_idx, step;
  logic              press_evt, good_evt, fail_evt, timeout_evt;
  logic [TMW-1:0]    timer;

`ifdef PARAM_LOCK_ENTRY_TIMEOUT_EN
  localparam int TOW = $clog2(ENTRY_TIMEOUT + 1);
  logic [TOW-1:0] idle_cnt;
`endif

  // Synchroniser and edge history; ones at reset so switches already high are not presses.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      sync_p0 <= '1;
      sync_p1 <= '1;
      hist_p2 <= '1;
    end else begin
      sync_p0 <= sw;
      sync_p1 <= sync_p0;
      hist_p2 <= sync_p1;
    end
  end

  // Stage p2: rising edges, press classification, and a live compare with the current code step.
  always_comb begin
    rise        = sync_p1 & ~hist_p2;
    any_rise    = |rise;
    single_rise = any_rise && ((rise & (rise - NUM_SW'(1))) == '0);
    rise_idx    = '0;
    for (int i = 0; i < NUM_SW; i++)
      if (rise[i]) rise_idx = IDX_W'(i);
    step = '0;
    for (int i = 0; i < CODE_LEN; i++)
      if (progress == PW'(i)) step = code_seq[i*IDX_W +: IDX_W];
    step_match  = single_rise && (int'(step) < NUM_SW) && (step == rise_idx);
    press_evt   = any_rise && !relock && (state == IDLE || state == ENTRY);
    good_evt    = press_evt && step_match;
`ifdef PARAM_LOCK_ENTRY_TIMEOUT_EN
    timeout_evt = (state == ENTRY) && !relock && !any_rise && (idle_cnt == TOW'(1));
`else
    timeout_evt = 1'b0;
`endif
    fail_evt    = (press_evt && !step_match) || timeout_evt;
  end

  // Lock FSM with registered outputs and a shared unlock/lockout timer.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state    <= IDLE;
      locked   <= 1'b1;
      alarm    <= 1'b0;
      fail_cnt <= '0;
      progress <= '0;
      timer    <= '0;
`ifdef PARAM_LOCK_ENTRY_TIMEOUT_EN
      idle_cnt <= '0;
`endif
    end else if (fail_evt) begin
      progress <= '0;
      fail_cnt <= fail_cnt + 1'b1;
      if (fail_cnt == FW'(MAX_FAILS - 1)) begin
        state <= ALARM;
        alarm <= 1'b1;
        timer <= TMW'(LOCKOUT_CYCLES);
      end else begin
        state <= IDLE;
      end
    end else begin
      case (state)
        IDLE, ENTRY: begin
          if (relock) begin
            state    <= IDLE;
            progress <= '0;
          end else if (good_evt) begin
`ifdef PARAM_LOCK_ENTRY_TIMEOUT_EN
            idle_cnt <= TOW'(ENTRY_TIMEOUT);
`endif
            if (progress == PW'(CODE_LEN - 1)) begin
              state    <= UNLOCKED;
              locked   <= 1'b0;
              progress <= '0;
              fail_cnt <= '0;
              timer    <= TMW'(UNLOCK_CYCLES);
            end else begin
              state    <= ENTRY;
              progress <= progress + 1'b1;
            end
          end
`ifdef PARAM_LOCK_ENTRY_TIMEOUT_EN
          else if (state == ENTRY) begin
            idle_cnt <= idle_cnt - 1'b1;
          end
`endif
        end
        UNLOCKED: begin
          if (relock || timer == TMW'(1)) begin
            state  <= IDLE;
            locked <= 1'b1;
          end
          timer <= timer - 1'b1;
        end
        default: begin
          if (timer == TMW'(1)) begin
            state    <= IDLE;
            alarm    <= 1'b0;
            fail_cnt <= '0;
          end
          timer <= timer - 1'b1;
        end
      endcase
    end
  end

  assign state_out = state;

endmodule

// File: tb/tb_param_digital_lock.sv
// Bench for param_digital_lock. It uses directed key-press vectors with hand-computed
// checks. A behavioural lock model is compared against the DUT on every cycle.
// It honours PARAM_LOCK_ENTRY_TIMEOUT_EN in the same way as the design.
module tb_param_digital_lock;

  localparam int NSW = 8;
  localparam int CL  = 4;
  localparam int UC  = 10;
  localparam int MF  = 3;
  localparam int LC  = 50;
  localparam int TO  = 20;

  logic        clk = 1'b0;
  logic        clear_n;
  logic [7:0]  sw;
  logic [11:0] code_seq;
  logic        relock;
  logic        locked, alarm;
  logic [1:0]  fail_cnt;
  logic [2:0]  progress;
  logic [1:0]  state_out;

  int tests = 0;
  int fails = 0;
  bit cmp_en = 1'b0;

  param_digital_lock #(
    .NUM_SW(NSW), .IDX_W(3), .CODE_LEN(CL), .UNLOCK_CYCLES(UC),
    .MAX_FAILS(MF), .LOCKOUT_CYCLES(LC), .ENTRY_TIMEOUT(TO)
  ) dut (
    .clk(clk), .clear_n(clear_n), .sw(sw), .code_seq(code_seq), .relock(relock),
    .locked(locked), .alarm(alarm), .fail_cnt(fail_cnt), .progress(progress),
    .state_out(state_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a key press is seen two clocks after its first sample.
  // The model state is plain integers (0 idle, 1 entry, 2 unlocked, 3 alarm).
  logic [7:0] d0, d1, d2;
  int m_state, m_prog, m_fail, m_timer, m_idle;

  task automatic m_failure();
    m_prog = 0;
    m_fail++;
    if (m_fail == MF) begin
      m_state = 3;
      m_timer = LC;
    end else begin
      m_state = 0;
    end
  endtask

  always @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      m_state = 0; m_prog = 0; m_fail = 0; m_timer = 0; m_idle = 0;
      d0 = '1; d1 = '1; d2 = '1;
    end else begin
      logic [7:0] r;
      int nr, idx, stp;
      bit timeout_on;
      r  = d1 & ~d2;
      d2 = d1; d1 = d0; d0 = sw;
      nr = $countones(r);
      idx = 0;
      for (int i = 0; i < NSW; i++) if (r[i]) idx = i;
`ifdef PARAM_LOCK_ENTRY_TIMEOUT_EN
      timeout_on = 1'b1;
`else
      timeout_on = 1'b0;
`endif
      case (m_state)
        0, 1: begin
          if (relock) begin
            m_state = 0; m_prog = 0;
          end else if (nr > 0) begin
            stp = int'((code_seq >> (3 * m_prog)) & 12'h7);
            if (nr == 1 && stp < NSW && stp == idx) begin
              m_prog++;
              m_idle = TO;
              if (m_prog == CL) begin
                m_state = 2; m_prog = 0; m_fail = 0; m_timer = UC;
              end else begin
                m_state = 1;
              end
            end else begin
              m_failure();
            end
          end else if (m_state == 1 && timeout_on) begin
            m_idle--;
            if (m_idle == 0) m_failure();
          end
        end
        2: begin
          m_timer--;
          if (relock || m_timer == 0) m_state = 0;
        end
        default: begin
          m_timer--;
          if (m_timer == 0) begin
            m_state = 0; m_fail = 0;
          end
        end
      endcase
    end
  end

  // Compare the DUT against the model on every falling edge once it is out of its first reset.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_locked",   int'(locked),    (m_state == 2) ? 0 : 1);
      chk("model_alarm",    int'(alarm),     (m_state == 3) ? 1 : 0);
      chk("model_fail_cnt", int'(fail_cnt),  m_fail);
      chk("model_progress", int'(progress),  m_prog);
      chk("model_state",    int'(state_out), m_state);
    end
  end

  // Pulse one or more switches for one cycle, then wait until the FSM has acted on the pulse.
  task automatic pulse(input logic [7:0] pat);
    @(negedge clk); sw = pat;
    @(negedge clk); sw = 8'h00;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic press(input int k);
    logic [7:0] p;
    p = 8'h01 << k;
    pulse(p);
  endtask

  initial begin
    int n;
    clear_n  = 1'b0;
    sw       = 8'h00;
    relock   = 1'b0;
    code_seq = {3'd0, 3'd7, 3'd1, 3'd3};
    repeat (3) @(negedge clk);
    #2 clear_n = 1'b1;
    cmp_en = 1'b1;
    @(negedge clk);
    chk("reset_locked", int'(locked), 1);
    chk("reset_alarm", int'(alarm), 0);
    chk("reset_state", int'(state_out), 0);
    chk("reset_fail", int'(fail_cnt), 0);

    // Correct code, then measure how long the lock stays open.
    press(3); chk("code_prog1", int'(progress), 1); chk("code_entry", int'(state_out), 1);
    press(1); chk("code_prog2", int'(progress), 2);
    press(7); chk("code_prog3", int'(progress), 3);
    press(0); chk("code_open", int'(locked), 0);
    n = 0;
    while (locked == 1'b0 && n < 100) begin n++; @(negedge clk); end
    chk("unlock_cycles", n, 10);
    chk("after_unlock_state", int'(state_out), 0);
    chk("after_unlock_fail", int'(fail_cnt), 0);

    // A wrong third step, then the correct code, then an early relock.
    press(3); press(1); press(5);
    chk("wrong_fail", int'(fail_cnt), 1);
    chk("wrong_prog", int'(progress), 0);
    chk("wrong_state", int'(state_out), 0);
    press(3); press(1); press(7); press(0);
    chk("retry_open", int'(locked), 0);
    chk("retry_fail_clr", int'(fail_cnt), 0);
    repeat (3) @(negedge clk);
    relock = 1'b1;
    @(negedge clk); relock = 1'b0;
    chk("relock_locked", int'(locked), 1);
    chk("relock_state", int'(state_out), 0);

    // Three wrong attempts trigger the alarm. Presses made during lockout are ignored.
    press(6); chk("bad1", int'(fail_cnt), 1);
    press(6); chk("bad2", int'(fail_cnt), 2);
    press(6); chk("alarm_on", int'(alarm), 1); chk("alarm_state", int'(state_out), 3);
    n = 0;
    while (alarm == 1'b1 && n < 200) begin
      sw = (n % 4 == 1 && n < 40) ? 8'h08 : 8'h00;
      n++;
      @(negedge clk);
    end
    sw = 8'h00;
    chk("lockout_cycles", n, 50);
    chk("lockout_fail_clr", int'(fail_cnt), 0);
    chk("lockout_prog", int'(progress), 0);
    chk("lockout_locked", int'(locked), 1);

    // Two switches rising together count as a wrong press.
    pulse(8'h28);
    chk("double_fail", int'(fail_cnt), 1);
    chk("double_state", int'(state_out), 0);

    // Reset in the middle of an entry, with sw[3] held high through reset release.
    press(3); press(1);
    chk("mid_prog", int'(progress), 2);
    sw = 8'h08;
    #2 clear_n = 1'b0;
    #1;
    chk("rst_locked", int'(locked), 1);
    chk("rst_prog", int'(progress), 0);
    chk("rst_fail", int'(fail_cnt), 0);
    chk("rst_state", int'(state_out), 0);
    repeat (2) @(negedge clk);
    #2 clear_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("held_no_press_prog", int'(progress), 0);
    chk("held_no_press_state", int'(state_out), 0);
    sw = 8'h00;
    repeat (3) @(negedge clk);

    // Single press followed by a long idle period.
    press(3);
    chk("idle_start_prog", int'(progress), 1);
    repeat (25) @(negedge clk);
`ifdef PARAM_LOCK_ENTRY_TIMEOUT_EN
    chk("timeout_fail", int'(fail_cnt), 1);
    chk("timeout_state", int'(state_out), 0);
    chk("timeout_prog", int'(progress), 0);
`else
    chk("no_timeout_state", int'(state_out), 1);
    chk("no_timeout_prog", int'(progress), 1);
    chk("no_timeout_fail", int'(fail_cnt), 0);
`endif

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Absolute guard so the bench always ends.
  initial begin
    #200000;
    fails++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
